// File: rtl/aqua_condition_encoder_pkg.sv
// Shared condition codes for the aquaculture controller (encoder and actuator FSM).
package aqua_condition_encoder_pkg;

  typedef enum logic [1:0] {
    COND_NORMAL   = 2'b00,
    COND_WARNING  = 2'b01,
    COND_CRITICAL = 2'b10
  } cond_e;

endpackage

// File: rtl/aqua_condition_encoder_sev_classify.sv
// Combinational severity classifier for one DO/temperature sample.
// MARGIN widens every threshold toward the safe side for hysteretic clearing.
module aqua_condition_encoder_sev_classify
  import aqua_condition_encoder_pkg::*;
#(
  parameter int W         = 8,
  parameter int DO_WARN   = 60,
  parameter int DO_CRIT   = 40,
  parameter int TEMP_WARN = 30,
  parameter int TEMP_CRIT = 34,
  parameter int MARGIN    = 0
) (
  input  logic [W-1:0] do_level,
  input  logic [W-1:0] temp,
  output cond_e        sev
);

  // Thresholds live in W+1 bits so DO + margin cannot wrap.
  localparam logic [W:0] DO_WARN_THR   = (W+1)'(DO_WARN + MARGIN);
  localparam logic [W:0] DO_CRIT_THR   = (W+1)'(DO_CRIT + MARGIN);
  localparam logic [W:0] TEMP_WARN_THR = (W+1)'(TEMP_WARN - MARGIN);
  localparam logic [W:0] TEMP_CRIT_THR = (W+1)'(TEMP_CRIT - MARGIN);

  logic [W:0] do_ext;
  logic [W:0] temp_ext;

  assign do_ext   = {1'b0, do_level};
  assign temp_ext = {1'b0, temp};

  always_comb begin
    sev = COND_NORMAL;
    if (do_ext < DO_CRIT_THR || temp_ext >= TEMP_CRIT_THR) begin
      sev = COND_CRITICAL;
    end else if (do_ext < DO_WARN_THR || temp_ext >= TEMP_WARN_THR) begin
      sev = COND_WARNING;
    end
  end

endmodule

// File: rtl/aqua_condition_encoder.sv
// Filters per-sample severity with persistence counts and hysteresis into the
// 2-bit condition code; a watchdog forces CRITICAL when samples stop.
module aqua_condition_encoder
  import aqua_condition_encoder_pkg::*;
#(
  parameter int W           = 8,
  parameter int DO_WARN     = 60,
  parameter int DO_CRIT     = 40,
  parameter int TEMP_WARN   = 30,
  parameter int TEMP_CRIT   = 34,
  parameter int HYST        = 2,
  parameter int ESC_CNT     = 3,
  parameter int DEESC_CNT   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] do_level,
  input  logic [W-1:0] temp,
  output logic         I1,
  output logic         I0,
  output logic         cond_valid,
  output logic         cond_changed,
  output logic         stale
);

  localparam int UP_W = (ESC_CNT   < 2) ? 1 : $clog2(ESC_CNT + 1);
  localparam int DN_W = (DEESC_CNT < 2) ? 1 : $clog2(DEESC_CNT + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  localparam logic [UP_W:0]   ESC_LIM   = (UP_W+1)'(ESC_CNT);
  localparam logic [DN_W:0]   DEESC_LIM = (DN_W+1)'(DEESC_CNT);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

  cond_e raw_sev;
  cond_e clr_sev;

  cond_e           state, state_n;
  logic [UP_W-1:0] up_cnt, up_n;
  logic [DN_W-1:0] dn_cnt, dn_n;
  logic [WD_W-1:0] wd, wd_n;
  logic            stale_n, valid_n, changed_n;
  logic [UP_W:0]   up_inc;
  logic [DN_W:0]   dn_inc;

  aqua_condition_encoder_sev_classify #(
    .W(W), .DO_WARN(DO_WARN), .DO_CRIT(DO_CRIT),
    .TEMP_WARN(TEMP_WARN), .TEMP_CRIT(TEMP_CRIT), .MARGIN(0)
  ) u_raw (
    .do_level(do_level),
    .temp    (temp),
    .sev     (raw_sev)
  );

  aqua_condition_encoder_sev_classify #(
    .W(W), .DO_WARN(DO_WARN), .DO_CRIT(DO_CRIT),
    .TEMP_WARN(TEMP_WARN), .TEMP_CRIT(TEMP_CRIT), .MARGIN(HYST)
  ) u_clr (
    .do_level(do_level),
    .temp    (temp),
    .sev     (clr_sev)
  );

  assign up_inc = {1'b0, up_cnt} + (UP_W+1)'(1);
  assign dn_inc = {1'b0, dn_cnt} + (DN_W+1)'(1);

  always_comb begin
    state_n   = state;
    up_n      = up_cnt;
    dn_n      = dn_cnt;
    wd_n      = wd;
    stale_n   = stale;
    valid_n   = 1'b0;
    if (sample_valid) begin
      // A sample always beats a watchdog expiry in the same cycle.
      wd_n    = '0;
      stale_n = 1'b0;
      valid_n = 1'b1;
      if (raw_sev > state) begin
        dn_n = '0;
        if (up_inc >= ESC_LIM) begin
          state_n = raw_sev;
          up_n    = '0;
        end else begin
          up_n = up_inc[UP_W-1:0];
        end
      end else if (clr_sev < state) begin
        up_n = '0;
        if (dn_inc >= DEESC_LIM) begin
          state_n = (state == COND_CRITICAL) ? COND_WARNING : COND_NORMAL;
          dn_n    = '0;
        end else begin
          dn_n = dn_inc[DN_W-1:0];
        end
      end else begin
        up_n = '0;
        dn_n = '0;
      end
    end else if (wd == WD_LAST) begin
      state_n = COND_CRITICAL;
      stale_n = 1'b1;
      valid_n = 1'b1;
      up_n    = '0;
      dn_n    = '0;
      wd_n    = '0;
    end else begin
      wd_n = wd + WD_W'(1);
    end
    changed_n = valid_n && (state_n != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COND_NORMAL;
      up_cnt       <= '0;
      dn_cnt       <= '0;
      wd           <= '0;
      stale        <= 1'b0;
      cond_valid   <= 1'b0;
      cond_changed <= 1'b0;
    end else begin
      state        <= state_n;
      up_cnt       <= up_n;
      dn_cnt       <= dn_n;
      wd           <= wd_n;
      stale        <= stale_n;
      cond_valid   <= valid_n;
      cond_changed <= changed_n;
    end
  end

  assign I1 = state[1];
  assign I0 = state[0];

endmodule

// File: tb/tb_aqua_condition_encoder.sv
// Directed bench for aqua_condition_encoder: table of samples with expected
// code/change/stale, plus hand sequences for watchdog expiry and mid-run reset.
module tb_aqua_condition_encoder;

  localparam int W          = 8;
  localparam int TIMEOUT    = 20;
  localparam int IDLE_AFTER = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_valid;
  logic [W-1:0] do_level;
  logic [W-1:0] temp;
  logic         I1, I0, cond_valid, cond_changed, stale;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] do_l;
    logic [W-1:0] tmp;
    logic [1:0]   code;
    logic         changed;
    logic         stl;
  } vec_t;

  vec_t vecs[$];
  int   part_a_len;

  aqua_condition_encoder #(
    .W(W), .ESC_CNT(3), .DEESC_CNT(4), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .do_level    (do_level),
    .temp        (temp),
    .I1          (I1),
    .I0          (I0),
    .cond_valid  (cond_valid),
    .cond_changed(cond_changed),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int d, input int t, input logic [1:0] c, input logic ch, input logic s);
    vec_t v;
    v.do_l = W'(d); v.tmp = W'(t); v.code = c; v.changed = ch; v.stl = s;
    vecs.push_back(v);
  endtask

  // Called one time unit after a rising edge; leaves the bench at the same phase.
  task automatic send(input vec_t v, input string tag);
    sample_valid = 1'b1;
    do_level     = v.do_l;
    temp         = v.tmp;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    check({tag, ".valid"},   32'(cond_valid),   32'd1);
    check({tag, ".code"},    32'({I1, I0}),     32'(v.code));
    check({tag, ".changed"}, 32'(cond_changed), 32'(v.changed));
    check({tag, ".stale"},   32'(stale),        32'(v.stl));
    repeat (IDLE_AFTER) begin
      @(posedge clk); #1;
    end
    check({tag, ".pulse_end"}, 32'(cond_valid), 32'd0);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      send(vecs[i], $sformatf("vec%0d", i));
    end
  endtask

  initial begin
    vec_t v;
    // 1: steady normal
    for (int i = 0; i < 5; i++) add(80, 25, 2'b00, 1'b0, 1'b0);
    // 2: interrupted warning run, then three in a row
    add(55, 25, 2'b00, 1'b0, 1'b0);
    add(55, 25, 2'b00, 1'b0, 1'b0);
    add(80, 25, 2'b00, 1'b0, 1'b0);
    add(55, 25, 2'b00, 1'b0, 1'b0);
    add(55, 25, 2'b00, 1'b0, 1'b0);
    add(55, 25, 2'b01, 1'b1, 1'b0);
    // 3: inside hysteresis band holds, outside steps down after 4
    for (int i = 0; i < 6; i++) add(61, 25, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(62, 25, 2'b01, 1'b0, 1'b0);
    add(62, 25, 2'b00, 1'b1, 1'b0);
    // 4: hot water escalates straight to critical, recovers one step per run
    add(80, 36, 2'b00, 1'b0, 1'b0);
    add(80, 36, 2'b00, 1'b0, 1'b0);
    add(80, 36, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(80, 25, 2'b10, 1'b0, 1'b0);
    add(80, 25, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(80, 25, 2'b01, 1'b0, 1'b0);
    add(80, 25, 2'b00, 1'b1, 1'b0);
    part_a_len = vecs.size();
    // 5b: recovery from stale-forced critical
    for (int i = 0; i < 3; i++) add(80, 25, 2'b10, 1'b0, 1'b0);
    add(80, 25, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(80, 25, 2'b01, 1'b0, 1'b0);
    add(80, 25, 2'b00, 1'b1, 1'b0);

    rst = 1'b1; sample_valid = 1'b0; do_level = '0; temp = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.code",    32'({I1, I0}),     32'd0);
    check("reset.valid",   32'(cond_valid),   32'd0);
    check("reset.changed", 32'(cond_changed), 32'd0);
    check("reset.stale",   32'(stale),        32'd0);

    run_vecs(0, part_a_len);

    // 5: watchdog expiry after TIMEOUT idle clocks since the last sample
    for (int i = IDLE_AFTER + 1; i <= TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (i == TIMEOUT - 1) begin
        check("wd.pre_valid", 32'(cond_valid), 32'd0);
        check("wd.pre_stale", 32'(stale),      32'd0);
      end
    end
    check("wd.valid",   32'(cond_valid),   32'd1);
    check("wd.code",    32'({I1, I0}),     32'd2);
    check("wd.changed", 32'(cond_changed), 32'd1);
    check("wd.stale",   32'(stale),        32'd1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("wd.pulse_end", 32'(cond_valid), 32'd0);
    end
    check("wd2.valid",   32'(cond_valid),   32'd1);
    check("wd2.changed", 32'(cond_changed), 32'd0);
    check("wd2.code",    32'({I1, I0}),     32'd2);
    @(posedge clk); #1;

    run_vecs(part_a_len, vecs.size());

    // Sample arriving on the cycle the watchdog would expire wins
    repeat (TIMEOUT - 1 - IDLE_AFTER) begin
      @(posedge clk); #1;
    end
    check("race.pre_valid", 32'(cond_valid), 32'd0);
    v.do_l = 8'd80; v.tmp = 8'd25; v.code = 2'b00; v.changed = 1'b0; v.stl = 1'b0;
    send(v, "race");

    // 6: reset mid escalation run discards the pending count
    v.do_l = 8'd55; v.tmp = 8'd25; v.code = 2'b00; v.changed = 1'b0; v.stl = 1'b0;
    send(v, "esc1");
    send(v, "esc2");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.code",  32'({I1, I0}),   32'd0);
    check("midrst.valid", 32'(cond_valid), 32'd0);
    check("midrst.stale", 32'(stale),      32'd0);
    send(v, "post1");
    send(v, "post2");
    v.code = 2'b01; v.changed = 1'b1;
    send(v, "post3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
